sp_bram_be: RTL and testbench
=============================

Name: sp_bram_be

Overview:
- Single-port, synchronous block RAM with per-byte write enables.
- Vendor-neutral replacement for RAMB16_S36/RAMB16_S9/altsyncram single-port use; default geometry is 512 x 32 (one 18Kb block).
- Sits behind bus slaves such as the Wishbone RAM wrapper, which supply the word address, byte selects and write strobe.

Parameters:
ADDR_W, 9, word address width; depth = 2**ADDR_W words
DATA_W, 32, data width; must be a multiple of 8
WRITE_MODE, 0, data_o on a write: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
SRVAL, 0, DATA_W-bit value loaded into data_o by reset

Ports:
clk_i  in  1  clock; all activity on the rising edge
rst_i  in  1  synchronous, active-low reset of the output register only
en_i  in  1  port enable; gates reads, writes and output update
we_i  in  1  write strobe
be_i  in  DATA_W/8  byte enables; bit n covers data bits [8n+7:8n]
addr_i  in  ADDR_W  word address
data_i  in  DATA_W  write data
data_o  out  DATA_W  registered read data

Behaviour:
- Storage: 2**ADDR_W words of DATA_W bits.
- Contents initialise to all zeros at time 0 and are never cleared by rst_i.
- Write: at a rising edge with en_i=1 and we_i=1, each byte lane n with be_i[n]=1 takes data_i's byte n at addr_i. Lanes with be_i[n]=0 keep their old value.
- we_i=1 with be_i=0 writes nothing, but is still a write cycle for WRITE_MODE output purposes.
- Read: at a rising edge with en_i=1 and we_i=0, data_o <= mem[addr_i]. Latency is 1 cycle, so data is valid after the edge that samples the address.
- Output on a write cycle (en_i=1, we_i=1):
  - WRITE_FIRST: data_o <= merged new word (written lanes new, others old).
  - READ_FIRST: data_o <= old word before the write.
  - NO_CHANGE: data_o holds its value.
- en_i=0: no write; data_o holds; rst_i is also ignored, so data_o holds even if rst_i=0.
- Reset: at a rising edge with rst_i=0 and en_i=1, data_o <= SRVAL. This overrides any read/write output update.
- A write requested in the same cycle as reset still updates memory.
- Power-up value of data_o is SRVAL.
- Out-of-range addresses cannot occur (address width exactly matches depth).
- Consecutive-cycle accesses to the same address: a read returns the value written on the previous edge (no bypass hazard).

Optional Feature:
- Macro SP_BRAM_PARITY_EN.
- When defined:
  - Adds ports dip_i (in, DATA_W/8) and dop_o (out, DATA_W/8).
  - Each word stores one extra bit per byte lane, written under the same be_i lane enable as its byte.
  - dop_o follows identical read, WRITE_MODE, en_i and reset rules as data_o; reset value is 0.
  - The RAM does not compute or check parity; the bits are plain stored data.
- When undefined: the ports are absent and no extra storage is inferred.

Test Plan:
- Reset/SRVAL: SRVAL=32'hDEADBEEF; rst_i=0, en_i=1 for one edge -> data_o=32'hDEADBEEF. Then rst_i=1, en_i=0, toggle clocks -> data_o unchanged.
- Full write/read: write 32'h12345678 to addr 9'h1FF with be_i=4'hF; read addr 9'h1FF next cycle -> data_o=32'h12345678 one edge after the address is sampled. Addr 9'h000 still reads 0.
- Byte lanes: preload 32'hAABBCCDD at addr 5; write 32'h11223344 with be_i=4'b0101 -> readback 32'hAA22CC44. Write with be_i=4'b0000 -> still 32'hAA22CC44.
- Write modes: addr 3 holds 32'h0; write 32'hCAFEF00D, be_i=4'hF. WRITE_FIRST -> data_o=32'hCAFEF00D at that edge; READ_FIRST -> 32'h0; NO_CHANGE -> previous data_o value.
- Enable/reset interaction: en_i=0 with we_i=1 writing 32'hFFFFFFFF to addr 7 -> memory unchanged, data_o holds. rst_i=0 with en_i=1, we_i=1 writing 32'h5A5A5A5A to addr 7 -> data_o=SRVAL, later read of addr 7 = 32'h5A5A5A5A.
- Parity (SP_BRAM_PARITY_EN): write data 32'h01020304, dip_i=4'b1010, be_i=4'hF; then write be_i=4'b0001 with dip_i=4'b0101 -> read gives dop_o=4'b1011.

Source files
------------

// File: rtl/sp_bram_be.sv
// Single-port block RAM with per-byte write enables, registered read and selectable write-mode output.
// Optional per-lane stored parity bits (dip_i/dop_o) are enabled by defining SP_BRAM_PARITY_EN.
module sp_bram_be #(
  parameter int                ADDR_W     = 9,
  parameter int                DATA_W     = 32,
  parameter int                WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] SRVAL      = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     data_i,
`ifdef SP_BRAM_PARITY_EN
  input  logic [DATA_W/8-1:0]   dip_i,
  output logic [DATA_W/8-1:0]   dop_o,
`endif
  output logic [DATA_W-1:0]     data_o
);

  localparam int NUM_LANES = DATA_W / 8;
  localparam int DEPTH     = 2 ** ADDR_W;
`ifdef SP_BRAM_PARITY_EN
  localparam int LANE_W    = 9;
`else
  localparam int LANE_W    = 8;
`endif

  // Each byte lane is its own narrow RAM so the lane enable maps directly onto a RAM write enable.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
`ifdef SP_BRAM_PARITY_EN
      localparam logic [LANE_W-1:0] LANE_SRVAL = {1'b0, SRVAL[8*gi +: 8]};
`else
      localparam logic [LANE_W-1:0] LANE_SRVAL = SRVAL[8*gi +: 8];
`endif

      logic [LANE_W-1:0] lane_mem [DEPTH] = '{default: '0};
      logic [LANE_W-1:0] lane_q_reg = LANE_SRVAL;
      logic [LANE_W-1:0] lane_wr_data;
      logic              lane_wr_en;

`ifdef SP_BRAM_PARITY_EN
      assign lane_wr_data = {dip_i[gi], data_i[8*gi +: 8]};
`else
      assign lane_wr_data = data_i[8*gi +: 8];
`endif
      assign lane_wr_en = en_i & we_i & be_i[gi];

      // Memory is never touched by rst_i; a write coinciding with reset still lands.
      always_ff @(posedge clk_i) begin
        if (lane_wr_en) begin
          lane_mem[addr_i] <= lane_wr_data;
        end
      end

      // Reset and all output updates are gated by en_i; NO_CHANGE simply skips the write-cycle update.
      always_ff @(posedge clk_i) begin
        if (en_i) begin
          if (!rst_i) begin
            lane_q_reg <= LANE_SRVAL;
          end else if (!we_i) begin
            lane_q_reg <= lane_mem[addr_i];
          end else if (WRITE_MODE == 0) begin
            lane_q_reg <= be_i[gi] ? lane_wr_data : lane_mem[addr_i];
          end else if (WRITE_MODE == 1) begin
            lane_q_reg <= lane_mem[addr_i];
          end
        end
      end

      assign data_o[8*gi +: 8] = lane_q_reg[7:0];
`ifdef SP_BRAM_PARITY_EN
      assign dop_o[gi] = lane_q_reg[8];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_sp_bram_be.sv
// Self-checking bench: three RAM instances (WRITE_FIRST / READ_FIRST / NO_CHANGE) share stimulus
// and are compared against a word-level array model after every clock edge.
module tb_sp_bram_be;

  localparam logic [31:0] SRV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  be  = 4'h0;
  logic [8:0]  addr = '0;
  logic [31:0] din = '0;
  logic [3:0]  dip = '0;
  logic [31:0] q_wf, q_rf, q_nc;
  logic [3:0]  p_wf, p_rf, p_nc;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [512];
  logic [3:0]  par_m [512];
  logic [31:0] exp_wf = SRV, exp_rf = SRV, exp_nc = SRV;
  logic [3:0]  pexp_wf = '0, pexp_rf = '0, pexp_nc = '0;

  always #5 clk = ~clk;

`ifdef SP_BRAM_PARITY_EN
  sp_bram_be #(.ADDR_W(9), .DATA_W(32), .WRITE_MODE(0), .SRVAL(SRV)) u_wf (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
    .data_i(din), .dip_i(dip), .dop_o(p_wf), .data_o(q_wf));
  sp_bram_be #(.ADDR_W(9), .DATA_W(32), .WRITE_MODE(1), .SRVAL(SRV)) u_rf (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
    .data_i(din), .dip_i(dip), .dop_o(p_rf), .data_o(q_rf));
  sp_bram_be #(.ADDR_W(9), .DATA_W(32), .WRITE_MODE(2), .SRVAL(SRV)) u_nc (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
    .data_i(din), .dip_i(dip), .dop_o(p_nc), .data_o(q_nc));
`else
  sp_bram_be #(.ADDR_W(9), .DATA_W(32), .WRITE_MODE(0), .SRVAL(SRV)) u_wf (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
    .data_i(din), .data_o(q_wf));
  sp_bram_be #(.ADDR_W(9), .DATA_W(32), .WRITE_MODE(1), .SRVAL(SRV)) u_rf (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
    .data_i(din), .data_o(q_rf));
  sp_bram_be #(.ADDR_W(9), .DATA_W(32), .WRITE_MODE(2), .SRVAL(SRV)) u_nc (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
    .data_i(din), .data_o(q_nc));
  assign p_wf = '0;
  assign p_rf = '0;
  assign p_nc = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/wf"}, q_wf, exp_wf);
    chk({tag, "/rf"}, q_rf, exp_rf);
    chk({tag, "/nc"}, q_nc, exp_nc);
`ifdef SP_BRAM_PARITY_EN
    chk({tag, "/pwf"}, {28'h0, p_wf}, {28'h0, pexp_wf});
    chk({tag, "/prf"}, {28'h0, p_rf}, {28'h0, pexp_rf});
    chk({tag, "/pnc"}, {28'h0, p_nc}, {28'h0, pexp_nc});
`endif
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic s_en, input logic s_we, input logic s_rst,
                      input logic [3:0] s_be, input logic [8:0] s_addr,
                      input logic [31:0] s_din, input logic [3:0] s_dip,
                      input string tag);
    logic [31:0] old_w, new_w;
    logic [3:0]  old_p, new_p;
    @(negedge clk);
    en = s_en; we = s_we; rst = s_rst; be = s_be; addr = s_addr; din = s_din; dip = s_dip;
    @(posedge clk);
    #1;
    old_w = mem_m[s_addr];
    old_p = par_m[s_addr];
    new_w = old_w;
    new_p = old_p;
    for (int b = 0; b < 4; b++) begin
      if (s_be[b]) begin
        new_w[8*b +: 8] = s_din[8*b +: 8];
        new_p[b]        = s_dip[b];
      end
    end
    if (s_en && s_we) begin
      mem_m[s_addr] = new_w;
      par_m[s_addr] = new_p;
    end
    if (s_en) begin
      if (!s_rst) begin
        exp_wf = SRV; exp_rf = SRV; exp_nc = SRV;
        pexp_wf = '0; pexp_rf = '0; pexp_nc = '0;
      end else if (!s_we) begin
        exp_wf = old_w; exp_rf = old_w; exp_nc = old_w;
        pexp_wf = old_p; pexp_rf = old_p; pexp_nc = old_p;
      end else begin
        exp_wf = new_w; exp_rf = old_w;
        pexp_wf = new_p; pexp_rf = old_p;
      end
    end
    $display("step %-10s en=%0b we=%0b rst=%0b be=%h addr=%h din=%h -> wf=%h rf=%h nc=%h",
             tag, s_en, s_we, s_rst, s_be, s_addr, s_din, q_wf, q_rf, q_nc);
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_m[i] = '0;
      par_m[i] = '0;
    end
    #1;
    check_all("powerup");

    // Reset, then hold with en low
    step(1, 0, 0, 4'h0, 9'h000, 32'h0, 4'h0, "reset");
    step(0, 0, 1, 4'h0, 9'h000, 32'h0, 4'h0, "hold0");
    step(0, 0, 1, 4'h0, 9'h1FF, 32'h0, 4'h0, "hold1");

    // Full word write/read at the top address; bottom address still zero
    step(1, 1, 1, 4'hF, 9'h1FF, 32'h12345678, 4'h0, "wr1ff");
    step(1, 0, 1, 4'h0, 9'h1FF, 32'h0, 4'h0, "rd1ff");
    step(1, 0, 1, 4'h0, 9'h000, 32'h0, 4'h0, "rd000");

    // Byte lanes
    step(1, 1, 1, 4'hF, 9'h005, 32'hAABBCCDD, 4'h0, "pre5");
    step(1, 1, 1, 4'b0101, 9'h005, 32'h11223344, 4'h0, "lane5");
    step(1, 0, 1, 4'h0, 9'h005, 32'h0, 4'h0, "rd5a");
    step(1, 1, 1, 4'b0000, 9'h005, 32'h99999999, 4'h0, "be0");
    step(1, 0, 1, 4'h0, 9'h005, 32'h0, 4'h0, "rd5b");

    // Write modes on a zero-filled address
    step(1, 1, 1, 4'hF, 9'h003, 32'hCAFEF00D, 4'h0, "wmode");
    step(1, 0, 1, 4'h0, 9'h003, 32'h0, 4'h0, "rd3");

    // Enable / reset interaction
    step(0, 1, 1, 4'hF, 9'h007, 32'hFFFFFFFF, 4'h0, "enoff");
    step(1, 0, 1, 4'h0, 9'h007, 32'h0, 4'h0, "rd7a");
    step(0, 0, 0, 4'h0, 9'h005, 32'h0, 4'h0, "rstnoen");
    step(1, 1, 0, 4'hF, 9'h007, 32'h5A5A5A5A, 4'h0, "rstwr");
    step(1, 0, 1, 4'h0, 9'h007, 32'h0, 4'h0, "rd7b");

    // Parity lanes (plain stored bits)
    step(1, 1, 1, 4'hF, 9'h00A, 32'h01020304, 4'b1010, "par1");
    step(1, 1, 1, 4'b0001, 9'h00A, 32'h000000FF, 4'b0101, "par2");
    step(1, 0, 1, 4'h0, 9'h00A, 32'h0, 4'h0, "parrd");

    // Randomised traffic, half of it concentrated on a few addresses
    for (int n = 0; n < 400; n++) begin
      logic [8:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) != 0,
           4'($urandom_range(0, 15)), ra, $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
